// File: rtl/mult_div_seq_if.sv
// Handshake/result bundle between the CPU control unit and the MULT/DIV sequencer.
// master = control unit side, slave = sequencer side.
interface mult_div_seq_if;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/mult_div_seq.sv
// 32-bit signed MULT (shift-add) / DIV (restoring) sequencer writing HI/LO in 33 cycles.
// Define MULTDIV_DIV_ZERO_EXC_EN for a 1-cycle divide-by-zero completion with div_zero pulse.
module mult_div_seq (
    input  logic          clk,
    input  logic          reset,
    mult_div_seq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIX} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_dz;
    // r_opa: multiplicand, or dividend shifting out while quotient shifts in.
    // r_opb: multiplier shifting right, or fixed divisor.
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_start_ok;
    logic        w_b_zero;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_madd;
    logic [31:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_busy;
    logic        w_fix;
    logic        w_fix_wr;

    assign w_start_ok = (r_state == S_IDLE) && bus.start;
    assign w_last     = (r_cnt == 6'd31);
    assign w_abs_a    = bus.a_in[31] ? (~bus.a_in + 32'd1) : bus.a_in;
    assign w_abs_b    = bus.b_in[31] ? (~bus.b_in + 32'd1) : bus.b_in;

`ifdef MULTDIV_DIV_ZERO_EXC_EN
    assign w_b_zero = bus.op && (bus.b_in == '0);
`else
    assign w_b_zero = 1'b0;
`endif

    // Multiply step: add into the upper half keeping the carry for the right shift.
    assign w_madd = {1'b0, r_acc[63:32]} + {1'b0, (r_opb[0] ? r_opa : 32'd0)};

    // Divide step: the 33-bit shifted remainder is compared, the difference fits 32 bits.
    assign w_shifted  = {r_acc[62:32], r_opa[31]};
    assign w_ge       = {r_acc[63:32], r_opa[31]} >= {1'b0, r_opb};
    assign w_diff     = w_shifted - r_opb;
    assign w_rem_next = w_ge ? w_diff : w_shifted;

    assign w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? (~r_opa + 32'd1) : r_opa;
    assign w_rem  = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    if (w_b_zero)    w_next = S_FIX;
                    else if (bus.op) w_next = S_DIV;
                    else             w_next = S_MULT;
                end
            end
            S_MULT:  if (w_last) w_next = S_FIX;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_fix    = (r_state == S_FIX);
        w_fix_wr = w_fix && !r_dz;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dz     <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fix;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_op     <= bus.op;
                        r_sign_a <= bus.a_in[31];
                        r_sign_b <= bus.b_in[31];
                        r_dz     <= w_b_zero;
                        r_opa    <= w_abs_a;
                        r_opb    <= w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MULT: begin
                    r_acc <= {w_madd, r_acc[31:1]};
                    r_opb <= {1'b0, r_opb[31:1]};
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DIV: begin
                    r_acc[63:32] <= w_rem_next;
                    r_opa        <= {r_opa[30:0], w_ge};
                    r_cnt        <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    if (w_fix_wr) begin
                        if (r_op) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULTDIV_DIV_ZERO_EXC_EN
    logic r_div_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_fix && r_dz;
        end
    end

    assign bus.div_zero = r_div_zero;
`else
    assign bus.div_zero = 1'b0;
`endif

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed scenarios plus randomized ops vs a
// plain-arithmetic reference model.
module tb_mult_div_seq;

    logic clk;
    logic reset;

    mult_div_seq_if bus();

    mult_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: signed 64-bit arithmetic, truncating division.
    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_prev, input logic [31:0] lo_prev,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        hi = hi_prev;
        lo = lo_prev;
        if (!op) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
`ifdef MULTDIV_DIV_ZERO_EXC_EN
            dz = 1'b1;
`else
            hi = a;
            lo = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
`endif
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Drives one request from just after an edge and waits (bounded) for done.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)     begin n_err++; $display("FAIL rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL rst_dz got %b want 0", bus.div_zero); end
        n_cmp++; if (bus.hi_out !== 32'd0)  begin n_err++; $display("FAIL rst_hi got %h want 0", bus.hi_out); end
        n_cmp++; if (bus.lo_out !== 32'd0)  begin n_err++; $display("FAIL rst_lo got %h want 0", bus.lo_out); end
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult_basic();
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd7;
        bus.b_in  = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 33; k++) begin
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL mult_busy_window edge E%0d got busy=%b done=%b want busy=1 done=0", k, bus.busy, bus.done);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (bus.done !== 1'b1)          begin n_err++; $display("FAIL mult_done got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0)          begin n_err++; $display("FAIL mult_busy_end got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", bus.hi_out); end
        n_cmp++; if (bus.lo_out !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo_out); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0)          begin n_err++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFEB;
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, cyc);
        n_cmp++; if (cyc != 33)                  begin n_err++; $display("FAIL b2b_mult_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.hi_out !== 32'h4000_0000) begin n_err++; $display("FAIL b2b_mult_hi got %h want 40000000", bus.hi_out); end
        n_cmp++; if (bus.lo_out !== 32'h0)       begin n_err++; $display("FAIL b2b_mult_lo got %h want 0", bus.lo_out); end
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
        n_cmp++; if (cyc != 33)                  begin n_err++; $display("FAIL b2b_div_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL b2b_div_lo got %h want fffffffd", bus.lo_out); end
        n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_div_hi got %h want ffffffff", bus.hi_out); end
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;
    endtask

    task automatic test_overflow();
        int cyc;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        n_cmp++; if (cyc != 33)                  begin n_err++; $display("FAIL ovf_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.lo_out !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo got %h want 80000000", bus.lo_out); end
        n_cmp++; if (bus.hi_out !== 32'h0)       begin n_err++; $display("FAIL ovf_hi got %h want 0", bus.hi_out); end
        n_cmp++; if (bus.div_zero !== 1'b0)      begin n_err++; $display("FAIL ovf_dz got %b want 0", bus.div_zero); end
        exp_hi = 32'h0;
        exp_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero();
        int          cyc;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        do_op(1'b1, 32'd5, 32'd0, cyc);
`ifdef MULTDIV_DIV_ZERO_EXC_EN
        n_cmp++; if (cyc != 1)              begin n_err++; $display("FAIL dz_lat got %0d want 1", cyc); end
        n_cmp++; if (bus.div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", bus.div_zero); end
        n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL dz_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi_out !== prev_hi) begin n_err++; $display("FAIL dz_hi_hold got %h want %h", bus.hi_out, prev_hi); end
        n_cmp++; if (bus.lo_out !== prev_lo) begin n_err++; $display("FAIL dz_lo_hold got %h want %h", bus.lo_out, prev_lo); end
        @(posedge clk); #1;
        n_cmp++; if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL dz_pulse got dz=%b done=%b want 0 0", bus.div_zero, bus.done);
        end
`else
        n_cmp++; if (cyc != 33)              begin n_err++; $display("FAIL dz_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.div_zero !== 1'b0)  begin n_err++; $display("FAIL dz_flag got %b want 0", bus.div_zero); end
        n_cmp++; if (bus.hi_out !== 32'd5)   begin n_err++; $display("FAIL dz_hi got %h want 5 (prev %h)", bus.hi_out, prev_hi); end
        n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff (prev %h)", bus.lo_out, prev_lo); end
        exp_hi = 32'd5;
        exp_lo = 32'hFFFF_FFFF;
`endif
    endtask

    task automatic test_ignore_start();
        int cyc;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd3;
        bus.b_in  = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            bus.start = (cyc == 5 || cyc == 20);
            bus.op    = 1'b1;
            bus.a_in  = $urandom;
            bus.b_in  = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        n_cmp++; if (cyc != 33)            begin n_err++; $display("FAIL ign_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.hi_out !== 32'd0)  begin n_err++; $display("FAIL ign_hi got %h want 0", bus.hi_out); end
        n_cmp++; if (bus.lo_out !== 32'd12) begin n_err++; $display("FAIL ign_lo got %h want c", bus.lo_out); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL ign_no_queue busy got %b want 0", bus.busy); end
        exp_hi = 32'd0;
        exp_lo = 32'd12;
    endtask

    task automatic test_reset_midop();
        int cyc;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 32'd1000;
        bus.b_in  = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_cmp++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0) begin
            n_err++; $display("FAIL midrst_hilo got %h/%h want 0/0", bus.hi_out, bus.lo_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_op(1'b0, 32'd2, 32'd2, cyc);
        n_cmp++; if (cyc != 33)            begin n_err++; $display("FAIL midrst_lat got %0d want 33", cyc); end
        n_cmp++; if (bus.lo_out !== 32'd4)  begin n_err++; $display("FAIL midrst_lo got %h want 4", bus.lo_out); end
        n_cmp++; if (bus.hi_out !== 32'd0)  begin n_err++; $display("FAIL midrst_hi got %h want 0", bus.hi_out); end
        exp_hi = 32'd0;
        exp_lo = 32'd4;
    endtask

    task automatic test_random();
        int          cyc, idle, want_lat;
        logic        op, dz;
        logic [31:0] a, b, hi, lo;
        for (int i = 0; i < 24; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'h8000_0000;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(op, a, b, exp_hi, exp_lo, hi, lo, dz);
            want_lat = dz ? 1 : 33;
            do_op(op, a, b, cyc);
            n_cmp++; if (cyc != want_lat) begin
                n_err++; $display("FAIL rnd_lat[%0d] op=%0d a=%h b=%h got %0d want %0d", i, op, a, b, cyc, want_lat);
            end
            n_cmp++; if (bus.hi_out !== hi || bus.lo_out !== lo) begin
                n_err++; $display("FAIL rnd_res[%0d] op=%0d a=%h b=%h got %h/%h want %h/%h", i, op, a, b, bus.hi_out, bus.lo_out, hi, lo);
            end
            n_cmp++; if (bus.div_zero !== dz) begin
                n_err++; $display("FAIL rnd_dz[%0d] got %b want %b", i, bus.div_zero, dz);
            end
            exp_hi = hi;
            exp_lo = lo;
            idle = $urandom_range(0, 4);
            if (idle > 0) begin
                repeat (idle) @(posedge clk);
                #1;
                n_cmp++; if (bus.done !== 1'b0 || bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) begin
                    n_err++; $display("FAIL rnd_hold[%0d] got done=%b %h/%h want 0 %h/%h", i, bus.done, bus.hi_out, bus.lo_out, exp_hi, exp_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_back_to_back();
        test_overflow();
        test_div_zero();
        test_ignore_start();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
